rv32i_operand_fetch: RTL

// - Decode-side sequencer that drives the half-word BRAM register-file read port and returns full 32-bit rs1/rs2 operands.
// - Sits between instruction decode (upstream) and execute (downstream). Each 32-bit register is read as two 16-bit halves:
//   low half at {bank 0, addr}, high half at {bank 1, addr}.
// - x0 and unused operands return 0 without a BRAM read. Valid/ready handshake on both sides.

---
 rtl/rv32i_opfetch_pkg.sv | 25 ++
 rtl/rv32i_operand_latch.sv | 35 +++
 rtl/rv32i_operand_fetch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rv32i_opfetch_pkg.sv
// Shared types and constants for the RV32I operand fetch sequencer.
`timescale 1ns/1ps
package rv32i_opfetch_pkg;
  localparam int XLEN   = 32;
  localparam int HALF_W = 16;
  localparam int RF_AW  = 8;

  localparam logic BANK_LO = 1'b0;
  localparam logic BANK_HI = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    R1L,
    R1H,
    R2L,
    R2H,
    TAIL,
    DONE
  } opfetch_state_e;

  // Half-word BRAM address: bit 5 picks the bank, upper bits stay zero.
  function automatic logic [RF_AW-1:0] rf_half_addr(input logic bank, input logic [4:0] reg_addr);
    return {{(RF_AW-6){1'b0}}, bank, reg_addr};
  endfunction
endpackage

// File: rtl/rv32i_operand_latch.sv
// One 32-bit operand register assembled from two half-word captures, with an
// optional writeback load that locks out later captures.
`timescale 1ns/1ps
module rv32i_operand_latch
  import rv32i_opfetch_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_cap_lo,
  input  logic              i_cap_hi,
  input  logic [HALF_W-1:0] i_half_data,
  input  logic              i_byp_load,
  input  logic [XLEN-1:0]   i_byp_data,
  output logic [XLEN-1:0]   o_data
);
  logic locked;

  // A writeback load wins over any half capture on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
      locked <= 1'b0;
    end else if (i_clear) begin
      o_data <= i_byp_load ? i_byp_data : '0;
      locked <= i_byp_load;
    end else if (i_byp_load) begin
      o_data <= i_byp_data;
      locked <= 1'b1;
    end else if (!locked) begin
      if (i_cap_lo) o_data[HALF_W-1:0]    <= i_half_data;
      if (i_cap_hi) o_data[XLEN-1:HALF_W] <= i_half_data;
    end
  end
endmodule

// File: rtl/rv32i_operand_fetch.sv
// Sequences four half-word register-file reads into full rs1/rs2 operands.
// Optional writeback bypass is enabled by defining OPFETCH_WB_BYPASS_EN.
`timescale 1ns/1ps
module rv32i_operand_fetch
  import rv32i_opfetch_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_rs1_addr,
  input  logic [4:0]        i_rs2_addr,
  input  logic              i_rs1_used,
  input  logic              i_rs2_used,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic              o_rf_rd_en,
  output logic [RF_AW-1:0]  o_rf_rd_addr,
  input  logic [HALF_W-1:0] i_rf_rd_data,
  input  logic              i_wb_en,
  input  logic [4:0]        i_wb_addr,
  input  logic [XLEN-1:0]   i_wb_data
);
  opfetch_state_e   state, state_nxt, pend;
  logic [4:0]       rs1_q, rs2_q, rs1_sel, rs2_sel;
  logic             need1_q, need2_q, need1_in, need2_in;
  logic             accept, byp1, byp2;
  logic [RF_AW-1:0] rd_addr_nxt;

  assign accept   = (state == IDLE) && i_valid && !i_flush;
  assign need1_in = i_rs1_used && (i_rs1_addr != 5'd0);
  assign need2_in = i_rs2_used && (i_rs2_addr != 5'd0);
  assign rs1_sel  = accept ? i_rs1_addr : rs1_q;
  assign rs2_sel  = accept ? i_rs2_addr : rs2_q;

  function automatic opfetch_state_e fetch_next(input opfetch_state_e s, input logic n1, input logic n2);
    opfetch_state_e r;
    case (s)
      IDLE:    r = n1 ? R1L : (n2 ? R2L : DONE);
      R1L:     r = R1H;
      R1H:     r = n2 ? R2L : TAIL;
      R2L:     r = R2H;
      R2H:     r = TAIL;
      default: r = DONE;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_valid) state_nxt = fetch_next(IDLE, need1_in, need2_in);
        DONE:    if (i_ready) state_nxt = IDLE;
        default: state_nxt = fetch_next(state, need1_q, need2_q);
      endcase
    end
  end

  always_comb begin
    rd_addr_nxt = o_rf_rd_addr;
    case (state_nxt)
      R1L:     rd_addr_nxt = rf_half_addr(BANK_LO, rs1_sel);
      R1H:     rd_addr_nxt = rf_half_addr(BANK_HI, rs1_sel);
      R2L:     rd_addr_nxt = rf_half_addr(BANK_LO, rs2_sel);
      R2H:     rd_addr_nxt = rf_half_addr(BANK_HI, rs2_sel);
      default: rd_addr_nxt = o_rf_rd_addr;
    endcase
  end

  // pend remembers which half the BRAM is returning this cycle; flush drops it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      pend         <= IDLE;
      o_ready      <= 1'b1;
      o_valid      <= 1'b0;
      o_rf_rd_en   <= 1'b0;
      o_rf_rd_addr <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      need1_q      <= 1'b0;
      need2_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      pend         <= (o_rf_rd_en && !i_flush) ? state : IDLE;
      o_ready      <= (state_nxt == IDLE);
      o_valid      <= (state_nxt == DONE);
      o_rf_rd_en   <= (state_nxt inside {R1L, R1H, R2L, R2H});
      o_rf_rd_addr <= rd_addr_nxt;
      if (accept) begin
        rs1_q   <= i_rs1_addr;
        rs2_q   <= i_rs2_addr;
        need1_q <= need1_in;
        need2_q <= need2_in;
      end
    end
  end

`ifdef OPFETCH_WB_BYPASS_EN
  logic byp_window, wb_hit, need1_sel, need2_sel;
  assign need1_sel  = accept ? need1_in : need1_q;
  assign need2_sel  = accept ? need2_in : need2_q;
  assign byp_window = accept || ((state != IDLE) && (state != DONE) && !i_flush);
  assign wb_hit     = i_wb_en && (i_wb_addr != 5'd0) && byp_window;
  assign byp1       = wb_hit && need1_sel && (i_wb_addr == rs1_sel);
  assign byp2       = wb_hit && need2_sel && (i_wb_addr == rs2_sel);
`else
  logic unused_wb;
  assign unused_wb = ^{i_wb_en, i_wb_addr, i_wb_data};
  assign byp1      = 1'b0;
  assign byp2      = 1'b0;
`endif

  rv32i_operand_latch u_rs1 (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (accept),
    .i_cap_lo    ((pend == R1L) && !i_flush),
    .i_cap_hi    ((pend == R1H) && !i_flush),
    .i_half_data (i_rf_rd_data),
    .i_byp_load  (byp1),
    .i_byp_data  (i_wb_data),
    .o_data      (o_rs1_data)
  );

  rv32i_operand_latch u_rs2 (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (accept),
    .i_cap_lo    ((pend == R2L) && !i_flush),
    .i_cap_hi    ((pend == R2H) && !i_flush),
    .i_half_data (i_rf_rd_data),
    .i_byp_load  (byp2),
    .i_byp_data  (i_wb_data),
    .o_data      (o_rs2_data)
  );
endmodule
